mmio_io_ctrl: RTL and testbench
===============================

# mmio_io_ctrl

Parametrised memory-mapped I/O controller that replaces the fixed single-switch/single-LED peripherals behind the CPU's MemOrIO path. Serves N_SW debounced switch channels and N_LED LED channels of DATA_W bits each, with per-LED blink mode and a sticky switch-change status register. Sits on the CPU I/O side (`io_read`/`io_write`, address from the ALU result), clocked by the CPU clock.

## Interface
- DATA_W, 16, bits per switch/LED channel (1..32)
- N_SW, 2, switch channels (1..16)
- N_LED, 2, LED channels (1..16)
- DEB_CYCLES, 20000, consecutive stable cycles to accept a switch change (>=2)
- BLINK_DIV, 2500000, cycles per blink half-period (>=2)
- ADDR_BASE, 32'hFFFFFC00, I/O window base; bits [7:0] must be zero

- clock  in  1  CPU clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- addr  in  32  byte address from ALU result
- io_read  in  1  I/O read strobe
- io_write  in  1  I/O write strobe
- wdata  in  32  write data; low DATA_W bits used
- rdata  out  32  read data, zero-extended from DATA_W
- sw_in  in  N_SW*DATA_W  raw asynchronous switch pins, channel i at [i*DATA_W +: DATA_W]
- led_out  out  N_LED*DATA_W  LED pins, same packing

## Operation
- Hit: addr[31:8] == ADDR_BASE[31:8]; offset = addr[7:0]; addr[1:0] ignored.
- Register map (offset):
  - 0x00+4i, i<N_SW: SW_DATA[i], RO, debounced value.
  - 0x40+4i, i<N_LED: LED_DATA[i], RW.
  - 0x80+4i, i<N_LED: LED_CTRL[i], RW, bit0 = blink enable, other bits read 0.
  - 0xC0: SW_STAT, RO, bit i = channel i changed since last read; read clears.
  - Any other offset, or index >= channel count: reads 0, writes ignored.
- Read: rdata combinational from current register state whenever io_read && hit; otherwise 0.
- Write: io_write && hit updates target register at rising edge. io_read and io_write both high: write performed, read data still reflects pre-edge value.
- Switch path per channel: two-flop synchroniser per bit -> comparator vs stable value. If synced != stable, counter increments; when counter == DEB_CYCLES-1 and still different, stable <= synced, counter <= 0, SW_STAT[i] <= 1. If synced == stable, counter <= 0. Any mismatch pattern change during counting does not restart counting; only a return to equality does.
- SW_STAT clear: on rising edge with io_read && hit && offset==0xC0, all bits cleared except bits being set in the same cycle (set wins).
- Blink: one shared prescaler counts 0..BLINK_DIV-1, wraps to 0 and toggles phase. led_out[i] = LED_DATA[i] when blink disabled; when enabled, LED_DATA[i] while phase=1, 0 while phase=0. Prescaler free-runs independent of LED_CTRL writes.

## Timing
- Reset (rst low, async): LED_DATA, LED_CTRL, sync flops, stable values, debounce counters, SW_STAT, prescaler, phase all 0. led_out = 0 immediately; rdata = 0 unless a read strobe is active (then returns reset values).
- Write latency: LED_DATA write at edge k visible on led_out after edge k (combinational from register).
- Switch latency: raw change stable from before edge k -> synced after edge k+1 -> SW_DATA updates at edge k+1+DEB_CYCLES; SW_STAT bit set same edge.
- Blink: phase toggles every BLINK_DIV cycles; first toggle at edge BLINK_DIV after reset release.
- Reset asserted mid-debounce or mid-blink aborts all counting; no partial state retained.
- Glitch shorter than DEB_CYCLES synced cycles: no SW_DATA change, no status bit.

## Test plan
- Reset: DATA_W=16, N_SW=2, N_LED=2, DEB_CYCLES=4, BLINK_DIV=8; hold rst low with sw_in=16'hFFFF per channel -> led_out=0, read 0xFFFFFC00 returns 0, read 0xFFFFFCC0 returns 0.
- LED write/read: write 32'h1234ABCD to 0xFFFFFC44 -> led_out[31:16]=16'hABCD next cycle, read 0xFFFFFC44 returns 32'h0000ABCD; write to 0xFFFFFC48 (index 2) -> no change, reads 0.
- Debounce: set channel 0 sw_in=16'h00A5 and hold -> SW_DATA[0] reads 0 for 5 edges, reads 16'h00A5 after edge 6; SW_STAT reads 1; read again -> 0.
- Glitch reject: pulse channel 1 to 16'h0001 for 3 cycles then back to 0 -> SW_DATA[1] stays 0, SW_STAT bit1 stays 0.
- Blink: LED_DATA[0]=16'h00FF, write 1 to 0xFFFFFC80 -> led_out[15:0] alternates 0 / 16'h00FF every 8 cycles; write 0 to LED_CTRL[0] -> steady 16'h00FF.
- Set-vs-clear collision: arrange channel 0 debounce completion on the same edge as a SW_STAT read -> rdata that cycle shows old value, bit0 reads 1 afterwards; async rst pulse mid-debounce -> counter restarts, SW_DATA stays 0.

Source files
------------

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl
// Memory-mapped I/O controller for the CPU I/O side. It serves N_SW debounced
// switch channels and N_LED LED channels, each DATA_W bits wide. Each LED
// channel has an optional blink mode, and a sticky switch-change status
// register records which switch channels have changed.
//
// Ports
//   clock     CPU clock; all state updates on the rising edge
//   rst       asynchronous reset, active low
//   addr      byte address from the ALU result
//   io_read   I/O read strobe
//   io_write  I/O write strobe
//   wdata     write data; only the low DATA_W bits are used
//   rdata     combinational read data, zero-extended to 32 bits
//   sw_in     raw switch pins; channel i is at [i*DATA_W +: DATA_W]
//   led_out   LED pins; same packing as sw_in
//
// Register map (offset from ADDR_BASE; addr[1:0] is ignored)
//   0x00+4i   SW_DATA[i]   RO  debounced switch value
//   0x40+4i   LED_DATA[i]  RW
//   0x80+4i   LED_CTRL[i]  RW  bit0 = blink enable
//   0xC0      SW_STAT      RO  bit i = channel i changed; reading clears it
module mmio_io_ctrl #(
    parameter int          DATA_W     = 16,
    parameter int          N_SW       = 2,
    parameter int          N_LED      = 2,
    parameter int          DEB_CYCLES = 20000,
    parameter int          BLINK_DIV  = 2500000,
    parameter logic [31:0] ADDR_BASE  = 32'hFFFFFC00
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic [31:0]             addr,
    input  logic                    io_read,
    input  logic                    io_write,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata,
    input  logic [N_SW*DATA_W-1:0]  sw_in,
    output logic [N_LED*DATA_W-1:0] led_out
);

    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam int BLK_W = $clog2(BLINK_DIV);

    logic       hit;
    logic [1:0] region;
    logic [3:0] idx;
    logic       rd_en;
    logic       wr_en;
    logic       stat_rd;

    assign hit     = (addr[31:8] == ADDR_BASE[31:8]);
    assign region  = addr[7:6];
    assign idx     = addr[5:2];
    assign rd_en   = io_read & hit;
    assign wr_en   = io_write & hit;
    assign stat_rd = rd_en && (region == 2'd3) && (idx == 4'd0);

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata};

    // Switch path
    logic [DATA_W-1:0] sw_meta   [N_SW];
    logic [DATA_W-1:0] sw_sync   [N_SW];
    logic [DATA_W-1:0] sw_stable [N_SW];
    logic [DEB_W-1:0]  deb_cnt   [N_SW];
    logic [N_SW-1:0]   sw_stat;
    logic [N_SW-1:0]   stat_set;

    // A channel is accepted when it has differed from the stable value for
    // DEB_CYCLES consecutive cycles. The counter does not restart when the
    // mismatch pattern changes; it restarts only when the value returns to
    // equality with the stable value.
    always_comb begin
        stat_set = '0;
        for (int i = 0; i < N_SW; i++) begin
            stat_set[i] = (sw_sync[i] != sw_stable[i]) &&
                          (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1));
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_SW; i++) begin
                sw_meta[i]   <= '0;
                sw_sync[i]   <= '0;
                sw_stable[i] <= '0;
                deb_cnt[i]   <= '0;
            end
            sw_stat <= '0;
        end else begin
            for (int i = 0; i < N_SW; i++) begin
                sw_meta[i] <= sw_in[i*DATA_W +: DATA_W];
                sw_sync[i] <= sw_meta[i];
                if (sw_sync[i] != sw_stable[i]) begin
                    if (stat_set[i]) begin
                        sw_stable[i] <= sw_sync[i];
                        deb_cnt[i]   <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
            // A status read clears the register, but a bit being set on the
            // same edge still survives.
            sw_stat <= (stat_rd ? '0 : sw_stat) | stat_set;
        end
    end

    // LED registers
    logic [DATA_W-1:0] led_data [N_LED];
    logic [N_LED-1:0]  blink_en;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_LED; i++) begin
                led_data[i] <= '0;
            end
            blink_en <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N_LED; i++) begin
                if (idx == 4'(i)) begin
                    if (region == 2'd1) begin
                        led_data[i] <= wdata[DATA_W-1:0];
                    end
                    if (region == 2'd2) begin
                        blink_en[i] <= wdata[0];
                    end
                end
            end
        end
    end

    // One shared blink prescaler. It runs freely and is not affected by
    // LED_CTRL writes.
    logic [BLK_W-1:0] blk_cnt;
    logic             phase;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            blk_cnt <= '0;
            phase   <= 1'b0;
        end else if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
            blk_cnt <= '0;
            phase   <= ~phase;
        end else begin
            blk_cnt <= blk_cnt + BLK_W'(1);
        end
    end

    for (genvar g = 0; g < N_LED; g++) begin : g_led
        assign led_out[g*DATA_W +: DATA_W] =
            (blink_en[g] && !phase) ? '0 : led_data[g];
    end

    // Read mux
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (region)
                2'd0: begin
                    for (int i = 0; i < N_SW; i++) begin
                        if (idx == 4'(i)) rdata[DATA_W-1:0] = sw_stable[i];
                    end
                end
                2'd1: begin
                    for (int i = 0; i < N_LED; i++) begin
                        if (idx == 4'(i)) rdata[DATA_W-1:0] = led_data[i];
                    end
                end
                2'd2: begin
                    for (int i = 0; i < N_LED; i++) begin
                        if (idx == 4'(i)) rdata[0] = blink_en[i];
                    end
                end
                default: begin
                    if (idx == 4'd0) rdata[N_SW-1:0] = sw_stat;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
module tb_mmio_io_ctrl;

    localparam int DATA_W = 16;
    localparam int N_SW   = 2;
    localparam int N_LED  = 2;
    localparam int DEB    = 4;
    localparam int BDIV   = 8;

    logic        clock;
    logic        rst;
    logic [31:0] addr;
    logic        io_read;
    logic        io_write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] sw_in;
    logic [31:0] led_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    logic [31:0] exp_q[$];

    mmio_io_ctrl #(
        .DATA_W    (DATA_W),
        .N_SW      (N_SW),
        .N_LED     (N_LED),
        .DEB_CYCLES(DEB),
        .BLINK_DIV (BDIV),
        .ADDR_BASE (32'hFFFFFC00)
    ) dut (
        .clock   (clock),
        .rst     (rst),
        .addr    (addr),
        .io_read (io_read),
        .io_write(io_write),
        .wdata   (wdata),
        .rdata   (rdata),
        .sw_in   (sw_in),
        .led_out (led_out)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Edges since the last reset release, used as the blink reference.
    always @(posedge clock or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        addr    = a;
        io_read = 1'b1;
        #1;
        check(tag, rdata, exp_q.pop_front());
        io_read = 1'b0;
    endtask

    task automatic read_clr(input logic [31:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        addr    = a;
        io_read = 1'b1;
        #1;
        check(tag, rdata, exp_q.pop_front());
        tick();
        io_read = 1'b0;
    endtask

    task automatic chk_led(input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        #1;
        check(tag, led_out, exp_q.pop_front());
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr     = a;
        wdata    = d;
        io_write = 1'b1;
        tick();
        io_write = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        addr     = '0;
        io_read  = 1'b0;
        io_write = 1'b0;
        wdata    = '0;
        sw_in    = 32'hFFFF_FFFF;

        // Reset state
        repeat (3) tick();
        chk_led(32'h0, "rst_led");
        peek(32'hFFFFFC00, 32'h0, "rst_sw0");
        peek(32'hFFFFFCC0, 32'h0, "rst_stat");
        peek(32'hFFFFFC40, 32'h0, "rst_led0");
        sw_in = 32'h0;
        tick();
        rst = 1'b1;
        tick();

        // LED write/read
        bus_write(32'hFFFFFC44, 32'h1234ABCD);
        chk_led(32'hABCD_0000, "led1_wr");
        peek(32'hFFFFFC44, 32'h0000ABCD, "led1_rd");
        bus_write(32'hFFFFFC48, 32'h5555_5555);
        peek(32'hFFFFFC48, 32'h0, "led_idx2_rd");
        chk_led(32'hABCD_0000, "led_idx2_nochg");
        peek(32'hFFFFFC10, 32'h0, "unmapped_rd");
        bus_write(32'hFFFFFC84, 32'hFFFF_FFFF);
        peek(32'hFFFFFC84, 32'h1, "ctrl1_rd");
        bus_write(32'hFFFFFC84, 32'h0);
        peek(32'hFFFFFD44, 32'h0, "miss_rd");
        // read and write together: read returns the pre-edge value
        addr = 32'hFFFFFC44; wdata = 32'h0000BEEF; io_write = 1'b1;
        peek(32'hFFFFFC44, 32'h0000ABCD, "rw_old");
        tick();
        io_write = 1'b0;
        peek(32'hFFFFFC44, 32'h0000BEEF, "rw_new");
        chk_led(32'hBEEF_0000, "rw_led");

        // Debounce: accepted at the 6th edge after the change
        sw_in[15:0] = 16'h00A5;
        for (int e = 1; e <= 6; e++) begin
            tick();
            peek(32'hFFFFFC00, (e < 6) ? 32'h0 : 32'h00A5, $sformatf("deb_e%0d", e));
        end
        read_clr(32'hFFFFFCC0, 32'h1, "stat_set");
        peek(32'hFFFFFCC0, 32'h0, "stat_cleared");

        // Glitch reject on channel 1
        sw_in[31:16] = 16'h0001;
        repeat (3) tick();
        sw_in[31:16] = 16'h0000;
        repeat (8) tick();
        peek(32'hFFFFFC04, 32'h0, "glitch_sw1");
        peek(32'hFFFFFCC0, 32'h0, "glitch_stat");

        // Blink, aligned to a fresh reset
        sw_in = 32'h0;
        rst = 1'b0;
        chk_led(32'h0, "arst_led");
        peek(32'hFFFFFC44, 32'h0, "arst_led1_rd");
        rst = 1'b1;
        bus_write(32'hFFFFFC40, 32'h0000_00FF);
        bus_write(32'hFFFFFC80, 32'h1);
        for (int n = 0; n < 40; n++) begin
            chk_led(((cyc / BDIV) % 2 == 1) ? 32'h0000_00FF : 32'h0,
                    $sformatf("blink_c%0d", cyc));
            tick();
        end
        bus_write(32'hFFFFFC80, 32'h0);
        for (int n = 0; n < 10; n++) begin
            chk_led(32'h0000_00FF, $sformatf("steady_c%0d", cyc));
            tick();
        end

        // Set-vs-clear collision on channel 0
        sw_in[15:0] = 16'h0003;
        repeat (5) tick();
        peek(32'hFFFFFC00, 32'h0, "coll_pre");
        read_clr(32'hFFFFFCC0, 32'h0, "coll_old");
        peek(32'hFFFFFCC0, 32'h1, "coll_setwins");
        peek(32'hFFFFFC00, 32'h3, "coll_sw0");
        read_clr(32'hFFFFFCC0, 32'h1, "coll_clr");
        peek(32'hFFFFFCC0, 32'h0, "coll_after");

        // Async reset mid-debounce restarts counting
        sw_in[31:16] = 16'h0007;
        repeat (2) tick();
        rst = 1'b0;
        chk_led(32'h0, "mid_rst_led");
        peek(32'hFFFFFC00, 32'h0, "mid_rst_sw0");
        rst = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            peek(32'hFFFFFC04, (e < 6) ? 32'h0 : 32'h0007, $sformatf("rst_deb_e%0d", e));
        end
        peek(32'hFFFFFC00, 32'h3, "rst_deb_sw0");
        peek(32'hFFFFFCC0, 32'h3, "rst_deb_stat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
